// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple slice,
// registered carry, start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, res, res_next, dsum_w;
  logic [DIGIT-1:0] dsum;
  logic             carry, ripple_c, c_top, c_out;
  logic [CW-1:0]    cnt;
  logic             last, accept;

  // Ripple slice; c_top is the carry into the slice's top bit, which on the
  // final digit is the carry into bit WIDTH-1.
  always_comb begin
    ripple_c = carry;
    c_top    = carry;
    dsum     = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_top = ripple_c;
      dsum[i]  = sa[i] ^ sb[i] ^ ripple_c;
      ripple_c = (sa[i] & sb[i]) | (ripple_c & (sa[i] ^ sb[i]));
    end
    c_out = ripple_c;
  end

  assign dsum_w   = WIDTH'(dsum);
  assign res_next = (res >> DIGIT) | (dsum_w << (WIDTH - DIGIT));
  assign last     = (cnt == CW'(N - 1));
  assign accept   = start && (state != RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> DIGIT;
      sb    <= sb >> DIGIT;
      res   <= res_next;
      carry <= c_out;
      cnt   <= cnt + CW'(1);
      if (last) begin
        s    <= res_next;
        cout <= c_out;
        ovf  <= c_top ^ c_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=1 and DIGIT=4 instances against an
// arithmetic reference model, plus hand-computed directed results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] st  = '0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a   = '0;
  logic [7:0] b   = '0;
  logic [1:0] bsy, dn, co, ov;
  logic [7:0] s0, s1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(bsy[0]), .done(dn[0]), .s(s0), .cout(co[0]), .ovf(ov[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(bsy[1]), .done(dn[1]), .s(s1), .cout(co[1]), .ovf(ov[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {cout, ovf, s} from plain integer arithmetic.
  function automatic logic [9:0] model_of(input logic [7:0] x, input logic [7:0] y,
                                          input logic ci, input logic sb_);
    int ux, uy, u, r;
    logic c;
    ux = int'(x);
    uy = int'(y);
    if (!sb_) begin
      u = ux + uy + int'(ci);
      r = int'($signed(x)) + int'($signed(y)) + int'(ci);
      c = (u > 255);
    end else begin
      u = ux - uy - int'(ci);
      r = int'($signed(x)) - int'($signed(y)) - int'(ci);
      c = (u >= 0);
    end
    return {c, (r < -128) || (r > 127), u[7:0]};
  endfunction

  function automatic logic [9:0] dut_res(input int k);
    return (k == 0) ? {co[0], ov[0], s0} : {co[1], ov[1], s1};
  endfunction

  // Timing model: an accepted op keeps the unit busy for N cycles, then
  // publishes its result with a one-cycle done.
  int         nn[2] = '{8, 2};
  int         m_left[2];
  logic       m_done[2];
  logic [9:0] m_res[2];
  logic [9:0] p_res[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
        m_res[k]  <= '0;
      end else if (m_left[k] > 0) begin
        m_left[k] <= m_left[k] - 1;
        m_done[k] <= (m_left[k] == 1);
        if (m_left[k] == 1) m_res[k] <= p_res[k];
      end else begin
        m_done[k] <= 1'b0;
        if (st[k]) begin
          p_res[k]  <= model_of(a, b, cin, sub);
          m_left[k] <= nn[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_left[k] != 0));
        check($sformatf("done%0d", k), 32'(dn[k]), 32'(m_done[k]));
        check($sformatf("res%0d", k), 32'(dut_res(k)), 32'(m_res[k]));
      end
    end
  end

  task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic sb_, input logic [7:0] es,
                        input logic ec, input logic eo, input int elat);
    int lat;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb_; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    lat = 1;
    while (!dn[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("op_latency", 32'(lat), 32'(elat));
    check("op_s", 32'(dut_res(k) & 10'h0FF), 32'(es));
    check("op_cout", 32'(dut_res(k) >> 9), 32'(ec));
    check("op_ovf", 32'((dut_res(k) >> 8) & 10'h1), 32'(eo));
  endtask

  task automatic count_done(input int k, input int cycles, input int exp);
    int n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (dn[k]) n++;
    end
    check("done_count", 32'(n), 32'(exp));
  endtask

  initial begin
    int idx;
    int d[3];
    int nd;
    int lat;

    #1;
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_s", 32'(s0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 9);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9);
    run_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 9);
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 9);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 9);
    run_op(1, 8'h99, 8'h77, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 3);

    // Start held high on the DIGIT=4 unit: done every 3 cycles.
    @(negedge clk);
    a = 8'h99; b = 8'h77; cin = 1'b0; sub = 1'b0; st[1] = 1'b1;
    nd = 0;
    for (idx = 1; idx <= 12; idx++) begin
      @(negedge clk);
      if (dn[1] && nd < 3) begin
        d[nd] = idx;
        nd++;
      end
    end
    st[1] = 1'b0;
    check("b2b_count", 32'(nd), 32'd3);
    check("b2b_first", 32'(d[0]), 32'd3);
    check("b2b_second", 32'(d[1]), 32'd6);
    check("b2b_third", 32'(d[2]), 32'd9);
    repeat (4) @(negedge clk);

    // Operands and start wiggle during RUN; only the captured pair counts.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      st[0] = i[0];
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
    end
    lat = 8;
    @(negedge clk);
    while (!dn[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd9);
    check("hold_s", 32'(s0), 32'h46);
    count_done(0, 12, 0);

    // Async reset at RUN cycle 4.
    @(negedge clk);
    a = 8'hAA; b = 8'h11; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bsy[0]), 32'd0);
    check("arst_done", 32'(dn[0]), 32'd0);
    check("arst_s", 32'(s0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(0, 12, 0);
    run_op(0, 8'hAA, 8'h11, 1'b0, 1'b0, 8'hBB, 1'b0, 1'b0, 9);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
